// File: rtl/cpu_bus_mem.sv
// cpu_bus_mem: mirrored RAM, loader-writable ROM and open-bus responder for the CPU bus,
// with a streaming loader that holds the CPU while an image is written.
module cpu_bus_mem #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RAM_AW = 11,
  parameter logic [ADDR_W-1:0] RAM_WINDOW = 'h2000,
  parameter int ROM_AW = 12,
  parameter logic [ADDR_W-1:0] ROM_BASE = 'hF000
) (
  input  logic              clk_ph1,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr_bus,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] Data_bus,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic              ld_err
);
  typedef enum logic {RUN, LOAD} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx, wr_addr, rd_off, wr_off;
  logic [DATA_W-1:0] ram [2**RAM_AW];
  logic [DATA_W-1:0] rom [2**ROM_AW];
  logic [DATA_W-1:0] wr_data;
  logic loading, accept, wr_en, ram_we, rom_we, rd_ram, rd_rom, wr_ram, wr_rom, err_nx;
  assign loading  = state == LOAD;
  assign ld_ready = loading;
  assign cpu_hold = loading;
  assign accept   = loading && ld_valid;
  assign rd_ram   = Addr_bus < RAM_WINDOW;
  assign rd_rom   = Addr_bus >= ROM_BASE;
  assign rd_off   = Addr_bus - ROM_BASE;
  assign wr_addr  = loading ? ptr : Addr_bus;
  assign wr_data  = loading ? ld_data : cpu_wdata;
  assign wr_off   = wr_addr - ROM_BASE;
  assign wr_ram   = wr_addr < RAM_WINDOW;
  assign wr_rom   = wr_addr >= ROM_BASE;
  // Writes are gated by reset so nothing lands while the block is held in reset.
  assign wr_en    = rst && (loading ? ld_valid : !cpu_rw);
  assign ram_we   = wr_en && wr_ram;
  assign rom_we   = wr_en && wr_rom && loading;
  always_comb begin
    state_nx = ld_start ? LOAD : (accept && ld_last) ? RUN : state;
    ptr_nx   = ld_start ? ld_base : accept ? ptr + 1'b1 : ptr;
    err_nx   = ld_start ? 1'b0 : (accept && !wr_ram && !wr_rom) ? 1'b1 : ld_err;
  end
  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      ptr <= '0;
      ld_err <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      ld_err <= err_nx;
    end
  end
  // Memory contents survive reset, so the arrays have no reset branch.
  always_ff @(posedge clk_ph1) begin
    if (ram_we) ram[wr_addr[RAM_AW-1:0]] <= wr_data;
    if (rom_we) rom[wr_off[ROM_AW-1:0]] <= wr_data;
  end
  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) Data_bus <= '0;
    else if (!loading) begin
      if (!cpu_rw) Data_bus <= cpu_wdata;
      else if (rd_ram) Data_bus <= ram[Addr_bus[RAM_AW-1:0]];
      else if (rd_rom) Data_bus <= rom[rd_off[ROM_AW-1:0]];
    end
  end
endmodule

// File: tb/tb_cpu_bus_mem.sv
// tb_cpu_bus_mem: directed test of cpu_bus_mem loader, decode, mirroring, open bus and reset.
module tb_cpu_bus_mem;
  logic clk_ph1 = 0, rst = 0;
  logic [15:0] Addr_bus = 16'hE000, ld_base = 0;
  logic cpu_rw = 1, ld_start = 0, ld_valid = 0, ld_last = 0;
  logic [7:0] cpu_wdata = 0, ld_data = 0, Data_bus;
  logic ld_ready, cpu_hold, ld_err;
  int checks = 0, errors = 0, hold_cnt = 0;
  logic [7:0] img [7] = '{8'hA2, 8'hFD, 8'h9A, 8'h28, 8'h68, 8'h69, 8'h41};

  cpu_bus_mem dut (
    .clk_ph1(clk_ph1), .rst(rst), .Addr_bus(Addr_bus), .cpu_rw(cpu_rw),
    .cpu_wdata(cpu_wdata), .Data_bus(Data_bus), .ld_start(ld_start), .ld_base(ld_base),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_hold(cpu_hold), .ld_err(ld_err)
  );

  always #5 clk_ph1 = ~clk_ph1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_ph1);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string tag);
    Addr_bus = a;
    cpu_rw = 1;
    step();
    chk(tag, Data_bus, exp);
    Addr_bus = 16'hE000;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    Addr_bus = a;
    cpu_rw = 0;
    cpu_wdata = d;
    step();
    cpu_rw = 1;
    Addr_bus = 16'hE000;
  endtask

  task automatic start(input logic [15:0] b);
    ld_start = 1;
    ld_base = b;
    step();
    ld_start = 0;
  endtask

  task automatic lb(input logic [7:0] d, input logic last);
    ld_valid = 1;
    ld_data = d;
    ld_last = last;
    step();
    ld_valid = 0;
    ld_last = 0;
  endtask

  initial begin
    #1;
    chk("rst_data", Data_bus, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_err", ld_err, 0);
    step();
    rst = 1;
    step();
    // load an image at F000 with a one-cycle valid gap
    ld_valid = 1;
    ld_data = 8'h99;
    start(16'hF000);
    ld_valid = 0;
    chk("start_ready", ld_ready, 1);
    hold_cnt += int'(cpu_hold);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        Addr_bus = 16'h0100;
        cpu_rw = 0;
        cpu_wdata = 8'h99;
        step();
        cpu_rw = 1;
        Addr_bus = 16'hE000;
        chk("load_cpu_wr_ignored", Data_bus, 0);
        hold_cnt += int'(cpu_hold);
      end
      lb(img[i], i == 6);
      hold_cnt += int'(cpu_hold);
    end
    chk("hold_cycles", hold_cnt, 8);
    chk("last_ready", ld_ready, 0);
    rd(16'hE000, 8'h00, "unmapped_after_rst");
    for (int i = 0; i < 7; i++) rd(16'hF000 + 16'(i), img[i], "rom_read");
    // RAM mirroring and open bus
    wr(16'h01FD, 8'h55);
    chk("ram_wr_echo", Data_bus, 8'h55);
    rd(16'h09FD, 8'h55, "mirror_09fd");
    rd(16'h11FD, 8'h55, "mirror_11fd");
    rd(16'h19FD, 8'h55, "mirror_19fd");
    rd(16'h2000, 8'h55, "open_bus_2000");
    // ROM write protection
    wr(16'hF003, 8'h77);
    chk("rom_wr_echo", Data_bus, 8'h77);
    rd(16'hF003, 8'h28, "rom_protect");
    // loader wrap FFFE -> 0000
    start(16'hFFFE);
    lb(8'h11, 0);
    lb(8'h22, 0);
    lb(8'h33, 1);
    chk("wrap_err", ld_err, 0);
    chk("wrap_hold", cpu_hold, 0);
    rd(16'hFFFE, 8'h11, "wrap_fffe");
    rd(16'hFFFF, 8'h22, "wrap_ffff");
    rd(16'h0000, 8'h33, "wrap_0000");
    rd(16'h0800, 8'h33, "wrap_0800_mirror");
    rd(16'hEFFF, 8'h33, "open_bus_efff");
    // unmapped loader byte sets sticky error
    start(16'h4000);
    lb(8'h5A, 1);
    chk("err_set", ld_err, 1);
    step();
    step();
    chk("err_sticky", ld_err, 1);
    // restart with simultaneous last byte
    start(16'h0300);
    chk("err_clr_on_start", ld_err, 0);
    lb(8'h01, 0);
    lb(8'h02, 0);
    ld_start = 1;
    ld_base = 16'h0400;
    lb(8'hAA, 1);
    ld_start = 0;
    chk("restart_hold", cpu_hold, 1);
    lb(8'hBB, 1);
    chk("restart_done", cpu_hold, 0);
    rd(16'h0300, 8'h01, "restart_0300");
    rd(16'h0302, 8'hAA, "restart_0302");
    rd(16'h0400, 8'hBB, "restart_0400");
    // reset in the middle of a load
    wr(16'h0502, 8'hC2);
    wr(16'h0503, 8'hC3);
    start(16'h0500);
    lb(8'hD0, 0);
    lb(8'hD1, 0);
    #2 rst = 0;
    #1;
    chk("midrst_hold", cpu_hold, 0);
    chk("midrst_ready", ld_ready, 0);
    chk("midrst_data", Data_bus, 0);
    step();
    rst = 1;
    step();
    chk("postrst_data", Data_bus, 0);
    rd(16'h0500, 8'hD0, "kept_0500");
    rd(16'h0501, 8'hD1, "kept_0501");
    rd(16'h0502, 8'hC2, "untouched_0502");
    rd(16'h0503, 8'hC3, "untouched_0503");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_bus_mem.md
# cpu_bus_mem

Synthesizable, parametrised memory responder for the CPU address/data bus. It replaces per-bench hard-coded program case tables with:
- mirrored RAM;
- loader-writable program ROM;
- open-bus behaviour for unmapped addresses;
- a streaming loader that holds the CPU while an image is written.

It sits between the CPU core and the bench or top level, driving the CPU's `Data_bus` input.

## Interface
- `ADDR_W`, 16: CPU address width.
- `DATA_W`, 8: data width.
- `RAM_AW`, 11: RAM index width (2 KB).
- `RAM_WINDOW`, 16'h2000: addresses below this value map to RAM, mirrored every 2^`RAM_AW` bytes.
- `ROM_AW`, 12: ROM index width (4 KB).
- `ROM_BASE`, 16'hF000: addresses ≥ this value map to ROM, mirrored every 2^`ROM_AW` bytes. `RAM_WINDOW` ≤ `ROM_BASE` is required.

Ports:
- `clk_ph1`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `Addr_bus`  in  `ADDR_W`  CPU address.
- `cpu_rw`  in  1  1 = read, 0 = write.
- `cpu_wdata`  in  `DATA_W`  CPU write data.
- `Data_bus`  out  `DATA_W`  registered read data to the CPU.
- `ld_start`  in  1  one-cycle pulse that begins a load at `ld_base`.
- `ld_base`  in  `ADDR_W`  load start address.
- `ld_valid`  in  1  loader byte valid.
- `ld_data`  in  `DATA_W`  loader byte.
- `ld_last`  in  1  marks the final byte; qualified by `ld_valid`.
- `ld_ready`  out  1  block accepts a loader byte.
- `cpu_hold`  out  1  high while loading; the CPU must stall or stay in reset.
- `ld_err`  out  1  sticky flag: a loader byte targeted an unmapped address.

## Operation
- **Address decode:**
  - RAM if `Addr_bus` < `RAM_WINDOW`; index = `Addr_bus[RAM_AW-1:0]`.
  - ROM if `Addr_bus` ≥ `ROM_BASE`; index = (`Addr_bus` − `ROM_BASE`) mod 2^`ROM_AW`.
  - Everything else is unmapped.
- **FSM states: RUN, LOAD.**
  - RUN → LOAD on `ld_start`: the load pointer is set to `ld_base`.
  - LOAD → RUN on a byte accepted with `ld_last`=1.
  - `ld_start` while in LOAD restarts the load: the pointer reloads `ld_base` and the FSM stays in LOAD.
- **RUN behaviour:**
  - Read: `Data_bus` ← mem[decode] on mapped addresses. On unmapped addresses `Data_bus` holds its last value (open bus).
  - Write (`cpu_rw`=0): RAM is written with `cpu_wdata`. Writes to ROM or unmapped addresses are discarded. `Data_bus` ← `cpu_wdata` (bus echo, which updates the open-bus value).
- **LOAD behaviour:**
  - `ld_ready`=1 and `cpu_hold`=1.
  - A byte is accepted when `ld_valid`=1. It is written to RAM or ROM by decode of the pointer, and the pointer then increments mod 2^`ADDR_W`.
  - A byte to an unmapped pointer is dropped and sets `ld_err`.
  - CPU writes are ignored in LOAD. `Data_bus` holds its value.
- **`ld_err`** clears only on reset or on `ld_start`.
- **Memory contents** are not cleared by reset. A reset in the middle of a load keeps the bytes already written.

## Timing
- **Reset values:** `Data_bus`=0, `ld_ready`=0, `cpu_hold`=0, `ld_err`=0, state RUN, pointer 0.
- **Read latency: 1 cycle.** `Addr_bus` is sampled at edge N, and `Data_bus` is valid after edge N until edge N+1.
- **Write:** takes effect at edge N. A read of the same address at edge N+1 returns the new data.
- **`ld_start`:**
  - `cpu_hold` and `ld_ready` rise after the edge that samples it.
  - An `ld_valid` present in that same cycle is not accepted.
- **Loader throughput:** one byte per cycle.
- **Last byte:** on the edge that accepts `ld_last`, `cpu_hold` and `ld_ready` both fall after that edge.
- **`ld_start` and a `ld_last` byte in the same cycle:** `ld_start` wins. The byte is written, then the pointer reloads `ld_base` and the FSM stays in LOAD.
- **Pointer wrap:** the pointer wraps FFFF → 0000 without error. The byte at 0000 goes to RAM.
- **Asynchronous reset assertion:**
  - `cpu_hold`, `ld_ready` and `Data_bus` clear immediately.
  - A write in the same cycle as the reset assertion is not guaranteed.

## Test plan
- **Load and run:** `ld_start` with `ld_base`=F000. Stream A2 FD 9A 28 68 69 41, with `ld_last` on 41, and with `ld_valid` deasserted for one cycle in the middle of the stream. Expected: `cpu_hold` high for 8 cycles. Then reads of F000..F006 return the same bytes. Reads of E000 return 00 (unmapped after reset).
- **RAM mirroring:** write 0x55 to 01FD. Expected: reads at 09FD, 11FD and 19FD each return 55 one cycle later. A read at 2000 holds 55 (open bus).
- **ROM protection and ROM mirror:** CPU write 0x77 to F003. Expected: `Data_bus` echoes 77, and a later read of F003 returns 28. Read FFFF → returns the byte at ROM index FFF.
- **Loader wrap and error:**
  - `ld_base`=FFFE, bytes 11 22 33 (`ld_last` on 33). Expected: FFFE=11, FFFF=22, 0000=33, `ld_err`=0.
  - Then `ld_base`=4000, one byte. Expected: `ld_err`=1, sticky until the next `ld_start`.
- **Restart and simultaneous events:** during a load at 0300, assert `ld_start` with `ld_base`=0400 on the same cycle as a `ld_last` byte AA. Expected: 0302 (or the current pointer) = AA, the FSM stays in LOAD, and the next byte lands at 0400.
- **Reset mid-load:** pull `rst` low after 2 of 4 bytes. Expected: `cpu_hold`=0 immediately, those 2 bytes are retained, the last 2 addresses are unchanged, and `Data_bus`=00.
